// File: rtl/credit_pkg.sv
// credit_pkg: shared state encoding and width helper for the buffered credit receiver
package credit_pkg;
  typedef enum logic [1:0] {HOLD, INIT, ACTIVE} state_e;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/credit_fifo_ram.sv
// credit_fifo_ram: flop-array FIFO with flush, full/empty flags and occupancy count
module credit_fifo_ram
  import credit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = cnt_width(DEPTH),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    occupancy
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction
  always_comb begin
    wr_ptr_d = flush ? '0 : wr_en ? inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = flush ? '0 : rd_en ? inc(rd_ptr_q) : rd_ptr_q;
    occ_d    = flush ? '0 : occ_q + CW'(wr_en) - CW'(rd_en);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end
  assign rd_data   = mem_q[rd_ptr_q];
  assign full      = occ_q == CW'(DEPTH);
  assign empty     = occ_q == '0;
  assign occupancy = occ_q;
endmodule

// File: rtl/credit_receiver_buffered.sv
// credit_receiver_buffered: credit-flow receiver with DEPTH-entry buffer, init/hold FSM,
// programmable credit withhold and sticky overflow detection
module credit_receiver_buffered
  import credit_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_sender_in_reset,
  output logic             push_receiver_in_reset,
  input  logic             push_valid,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_credit_stall,
  output logic             push_credit,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  input  logic [CW-1:0]    credit_initial,
  input  logic [CW-1:0]    credit_withhold,
  output logic [CW-1:0]    credit_count,
  output logic [CW-1:0]    credit_available,
  output logic             overflow
);
  localparam int CW1 = CW + 1;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, occupancy;
  logic [CW:0] sum;
  logic ovf_q, ovf_d, active, flush, pop_fire, wr_en, full, empty;
  always_comb begin
    state_d          = push_sender_in_reset ? HOLD : (state_q == HOLD) ? INIT : ACTIVE;
    active           = state_q == ACTIVE;
    flush            = state_d == HOLD;
    pop_valid        = !empty && state_q != HOLD;
    pop_fire         = pop_valid && pop_ready;
    credit_available = (cnt_q > credit_withhold) ? cnt_q - credit_withhold : '0;
    push_credit      = active && credit_available != '0 && !push_credit_stall;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    wr_en            = push_valid && active && (!full || pop_fire);
    ovf_d            = ovf_q | (push_valid && active && full && !pop_fire);
    sum              = {1'b0, cnt_q} + CW1'(pop_fire) - CW1'(push_credit);
    cnt_d            = flush ? '0
                     : (state_q == INIT) ? ((credit_initial > CW'(DEPTH)) ? CW'(DEPTH) : credit_initial)
                     : (sum > CW1'(DEPTH)) ? CW'(DEPTH) : sum[CW-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end
  credit_fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .wr_en     (wr_en),
    .wr_data   (push_data),
    .rd_en     (pop_fire),
    .rd_data   (pop_data),
    .full      (full),
    .empty     (empty),
    .occupancy (occupancy)
  );
  assign push_receiver_in_reset = rst | (state_q != ACTIVE);
  assign credit_count           = cnt_q;
  assign overflow               = ovf_q;
endmodule

// File: tb/tb_credit_receiver_buffered.sv
// tb_credit_receiver_buffered: directed and random stimulus against a queue-based reference model
module tb_credit_receiver_buffered;
  localparam int W = 8;
  localparam int D = 4;
  localparam int CW = 3;
  logic clk, rst, push_sender_in_reset, push_receiver_in_reset, push_valid, push_credit_stall;
  logic push_credit, pop_valid, pop_ready, overflow;
  logic [W-1:0] push_data, pop_data;
  logic [CW-1:0] credit_initial, credit_withhold, credit_count, credit_available;
  int checks = 0, errors = 0;
  int m_state, m_cnt;
  bit m_ovf;
  logic [W-1:0] m_q[$];

  credit_receiver_buffered #(.WIDTH(W), .DEPTH(D)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .push_sender_in_reset   (push_sender_in_reset),
    .push_receiver_in_reset (push_receiver_in_reset),
    .push_valid             (push_valid),
    .push_data              (push_data),
    .push_credit_stall      (push_credit_stall),
    .push_credit            (push_credit),
    .pop_valid              (pop_valid),
    .pop_ready              (pop_ready),
    .pop_data               (pop_data),
    .credit_initial         (credit_initial),
    .credit_withhold        (credit_withhold),
    .credit_count           (credit_count),
    .credit_available       (credit_available),
    .overflow               (overflow)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt = 0;
    m_ovf = 0;
    m_q.delete();
  endtask

  // compare outputs mid-cycle against the model, then advance the model by one clock
  task automatic step();
    int avail, nxt;
    bit pc, pv, fire;
    @(negedge clk);
    avail = (m_cnt > int'(credit_withhold)) ? m_cnt - int'(credit_withhold) : 0;
    pc = m_state == 2 && avail > 0 && !push_credit_stall;
    pv = m_state != 0 && m_q.size() > 0;
    chk("in_reset", push_receiver_in_reset, m_state != 2);
    chk("push_credit", push_credit, pc);
    chk("pop_valid", pop_valid, pv);
    if (pv) chk("pop_data", pop_data, m_q[0]);
    chk("credit_count", credit_count, m_cnt);
    chk("credit_available", credit_available, avail);
    chk("overflow", overflow, m_ovf);
    fire = pv && pop_ready;
    nxt = push_sender_in_reset ? 0 : (m_state == 0 ? 1 : 2);
    if (m_state == 2 && push_valid && m_q.size() == D && !fire) m_ovf = 1;
    if (nxt == 0) begin
      m_q.delete();
      m_cnt = 0;
    end else if (m_state == 1) begin
      m_cnt = (int'(credit_initial) > D) ? D : int'(credit_initial);
    end else begin
      if (fire) void'(m_q.pop_front());
      if (m_state == 2 && push_valid && m_q.size() < D) m_q.push_back(push_data);
      m_cnt = m_cnt + int'(fire) - int'(pc);
      if (m_cnt > D) m_cnt = D;
    end
    m_state = nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input int n, input logic [W-1:0] base);
    for (int i = 0; i < n; i++) begin
      push_valid = 1;
      push_data = base + W'(i);
      step();
    end
    push_valid = 0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_reset"}, push_receiver_in_reset, 1);
    chk({tag, "_count"}, credit_count, 0);
    chk({tag, "_credit"}, push_credit, 0);
    chk({tag, "_pop_valid"}, pop_valid, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  initial begin
    rst = 1;
    push_sender_in_reset = 0;
    push_valid = 0;
    push_data = '0;
    push_credit_stall = 0;
    pop_ready = 0;
    credit_initial = 3'd4;
    credit_withhold = 3'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_checks("rst");
    rst = 0;
    repeat (2) step();
    chk("init_count", credit_count, 4);
    repeat (6) step();
    chk("init_drained", credit_count, 0);
    push_beats(4, 8'hA1);
    step();
    chk("full_head", pop_data, 8'hA1);
    push_beats(1, 8'hA5);
    step();
    chk("ovf_sticky", overflow, 1);
    pop_ready = 1;
    repeat (6) step();
    pop_ready = 0;
    chk("popped_returned", credit_count, 0);
    credit_withhold = 3'd4;
    push_beats(3, 8'hB0);
    pop_ready = 1;
    repeat (3) step();
    pop_ready = 0;
    step();
    chk("held3", credit_count, 3);
    credit_withhold = 3'd2;
    repeat (3) step();
    chk("withhold2", credit_count, 2);
    credit_withhold = 3'd0;
    repeat (3) step();
    chk("withhold0", credit_count, 0);
    credit_withhold = 3'd4;
    push_beats(2, 8'hC0);
    pop_ready = 1;
    repeat (2) step();
    pop_ready = 0;
    credit_withhold = 3'd0;
    push_credit_stall = 1;
    repeat (3) step();
    chk("stall_hold", credit_count, 2);
    push_credit_stall = 0;
    repeat (3) step();
    chk("stall_release", credit_count, 0);
    push_beats(2, 8'hD0);
    push_sender_in_reset = 1;
    step();
    chk("hold_pop_valid", pop_valid, 0);
    chk("hold_in_reset", push_receiver_in_reset, 1);
    credit_initial = 3'd3;
    step();
    push_sender_in_reset = 0;
    repeat (2) step();
    chk("reinit_count", credit_count, 3);
    repeat (4) step();
    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        @(negedge clk);
        #2 rst = 1;
        #1 reset_checks("async");
        model_reset();
        @(posedge clk);
        #1 rst = 0;
      end
      push_valid = 1'($urandom_range(0, 1));
      push_data = 8'($urandom);
      pop_ready = 1'($urandom_range(0, 1));
      push_credit_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) credit_withhold = 3'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) credit_initial = 3'($urandom_range(0, 7));
      push_sender_in_reset = ($urandom_range(0, 39) == 0);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
